// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: sizes, FSM states, stage bundles.
// MEM_MISALIGN_TRAP_EN adds the misalign flag to inst_signal.
package common;
    localparam int DATA_W = 64;
    localparam int STRB_N = DATA_W / 8;

    typedef enum logic [1:0] {
        MSZ_B = 2'd0,
        MSZ_H = 2'd1,
        MSZ_W = 2'd2,
        MSZ_D = 2'd3
    } msize_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Low address bits that must be zero for an access of this size.
    function automatic logic [DATA_W-1:0] size_mask(input msize_t s);
        return (DATA_W'(1) << s) - DATA_W'(1);
    endfunction
endpackage

package temp_storage;
    import common::*;

    typedef struct packed {
        logic   mem_read;
        logic   mem_write;
        msize_t mem_size;
        logic   mem_unsigned;
`ifdef MEM_MISALIGN_TRAP_EN
        logic   misalign;
`endif
    } inst_signal_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        inst_signal_t      inst_signal;
        logic [4:0]        reg_dest_addr;
        logic              reg_write_enable;
        logic [31:0]       inst;
        logic [DATA_W-1:0] inst_pc;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]        reg_dest_addr;
        logic              reg_write_enable;
        logic [DATA_W-1:0] wb_value;
        logic [31:0]       inst;
        logic [DATA_W-1:0] inst_pc;
        inst_signal_t      inst_signal;
    } mem_wb_t;
endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane alignment: store strobe/data generation and
// load extract with sign or zero extension.
module mem_align
    import common::*;
#(
    parameter int XLEN = DATA_W,
    parameter int STRB_W = XLEN / 8,
    localparam int OW = $clog2(STRB_W)
) (
    input  logic [OW-1:0]     i_st_off,
    input  msize_t            i_st_size,
    input  logic [XLEN-1:0]   i_st_data,
    output logic [STRB_W-1:0] o_st_strobe,
    output logic [XLEN-1:0]   o_st_data,
    input  logic [OW-1:0]     i_ld_off,
    input  msize_t            i_ld_size,
    input  logic              i_ld_unsigned,
    input  logic [XLEN-1:0]   i_ld_data,
    output logic [XLEN-1:0]   o_ld_value
);
    logic [STRB_W-1:0] w_st_ones;
    logic [XLEN-1:0]   w_ld_raw;
    logic              w_fill;

    always_comb begin
        w_st_ones = '0;
        unique case (i_st_size)
            MSZ_B: w_st_ones = STRB_W'(8'h01);
            MSZ_H: w_st_ones = STRB_W'(8'h03);
            MSZ_W: w_st_ones = STRB_W'(8'h0F);
            MSZ_D: w_st_ones = '1;
        endcase
        o_st_strobe = w_st_ones << i_st_off;
        o_st_data   = i_st_data << {i_st_off, 3'b000};
    end

    assign w_ld_raw = i_ld_data >> {i_ld_off, 3'b000};

    always_comb begin
        w_fill     = 1'b0;
        o_ld_value = w_ld_raw;
        unique case (i_ld_size)
            MSZ_B: begin
                w_fill     = ~i_ld_unsigned & w_ld_raw[7];
                o_ld_value = {{(XLEN-8){w_fill}}, w_ld_raw[7:0]};
            end
            MSZ_H: begin
                w_fill     = ~i_ld_unsigned & w_ld_raw[15];
                o_ld_value = {{(XLEN-16){w_fill}}, w_ld_raw[15:0]};
            end
            MSZ_W: begin
                w_fill     = ~i_ld_unsigned & w_ld_raw[31];
                o_ld_value = {{(XLEN-32){w_fill}}, w_ld_raw[31:0]};
            end
            MSZ_D: o_ld_value = w_ld_raw;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-bus handshake for loads/stores, mem_wb register.
// MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them.
module mem_stage
    import common::*;
    import temp_storage::*;
#(
    parameter int XLEN = DATA_W,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  ex_mem_t           ex_mem_state,
    input  logic              ex_valid,
    output logic              mem_ready,
    output logic              dreq_valid,
    output logic [XLEN-1:0]   dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [STRB_W-1:0] dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output mem_wb_t           mem_wb_state,
    output logic              wb_valid
);
    localparam int OW = $clog2(STRB_W);

    mem_state_t        r_state;
    logic [XLEN-1:0]   r_addr;
    msize_t            r_size;
    logic [STRB_W-1:0] r_strobe;
    logic [XLEN-1:0]   r_data;
    inst_signal_t      r_sig;
    logic [4:0]        r_dest;
    logic              r_we;
    logic [31:0]       r_inst;
    logic [XLEN-1:0]   r_pc;
    mem_wb_t           r_wb;
    logic              r_wb_valid;

    logic              w_is_mem;
    logic [XLEN-1:0]   w_eff_addr;
    logic [STRB_W-1:0] w_st_strobe;
    logic [XLEN-1:0]   w_st_data;
    logic [XLEN-1:0]   w_ld_value;
    mem_wb_t           w_wb_alu;
    mem_wb_t           w_wb_mem;
    inst_signal_t      w_sig_in;

    assign w_is_mem = ex_mem_state.inst_signal.mem_read
                    | ex_mem_state.inst_signal.mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    logic    w_misalign;
    mem_wb_t w_wb_trap;

    assign w_misalign = w_is_mem & (|(ex_mem_state.alu_result
                      & size_mask(ex_mem_state.inst_signal.mem_size)));
    assign w_eff_addr = ex_mem_state.alu_result;
`else
    assign w_eff_addr = ex_mem_state.alu_result
                      & ~size_mask(ex_mem_state.inst_signal.mem_size);
`endif

    mem_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
        .i_st_off      (w_eff_addr[OW-1:0]),
        .i_st_size     (ex_mem_state.inst_signal.mem_size),
        .i_st_data     (ex_mem_state.store_data),
        .o_st_strobe   (w_st_strobe),
        .o_st_data     (w_st_data),
        .i_ld_off      (r_addr[OW-1:0]),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_sig.mem_unsigned),
        .i_ld_data     (dresp_data),
        .o_ld_value    (w_ld_value)
    );

    always_comb begin
        w_sig_in = ex_mem_state.inst_signal;
`ifdef MEM_MISALIGN_TRAP_EN
        w_sig_in.misalign = 1'b0;
`endif
        w_wb_alu = '0;
        w_wb_alu.reg_dest_addr    = ex_mem_state.reg_dest_addr;
        w_wb_alu.reg_write_enable = ex_mem_state.reg_write_enable;
        w_wb_alu.wb_value         = ex_mem_state.alu_result;
        w_wb_alu.inst             = ex_mem_state.inst;
        w_wb_alu.inst_pc          = ex_mem_state.inst_pc;
        w_wb_alu.inst_signal      = w_sig_in;
        // Stores never write the register file.
        w_wb_mem = '0;
        w_wb_mem.reg_dest_addr    = r_dest;
        w_wb_mem.reg_write_enable = r_sig.mem_read & r_we;
        w_wb_mem.wb_value         = r_sig.mem_read ? w_ld_value : '0;
        w_wb_mem.inst             = r_inst;
        w_wb_mem.inst_pc          = r_pc;
        w_wb_mem.inst_signal      = r_sig;
`ifdef MEM_MISALIGN_TRAP_EN
        w_wb_trap = w_wb_alu;
        w_wb_trap.reg_write_enable     = 1'b0;
        w_wb_trap.wb_value             = '0;
        w_wb_trap.inst_signal.misalign = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_size     <= MSZ_B;
            r_strobe   <= '0;
            r_data     <= '0;
            r_sig      <= '0;
            r_dest     <= '0;
            r_we       <= 1'b0;
            r_inst     <= '0;
            r_pc       <= '0;
            r_wb       <= '0;
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!w_is_mem) begin
                            r_wb       <= w_wb_alu;
                            r_wb_valid <= 1'b1;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        else if (w_misalign) begin
                            r_wb       <= w_wb_trap;
                            r_wb_valid <= 1'b1;
                        end
`endif
                        else begin
                            r_addr   <= w_eff_addr;
                            r_size   <= ex_mem_state.inst_signal.mem_size;
                            r_strobe <= ex_mem_state.inst_signal.mem_write
                                      ? w_st_strobe : '0;
                            r_data   <= w_st_data;
                            r_sig    <= w_sig_in;
                            r_dest   <= ex_mem_state.reg_dest_addr;
                            r_we     <= ex_mem_state.reg_write_enable;
                            r_inst   <= ex_mem_state.inst;
                            r_pc     <= ex_mem_state.inst_pc;
                            r_state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dresp_data_ok) begin
                        r_wb       <= w_wb_mem;
                        r_wb_valid <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign mem_ready    = (r_state == IDLE);
    assign dreq_valid   = (r_state == BUSY);
    assign dreq_addr    = r_addr;
    assign dreq_size    = {1'b0, r_size};
    assign dreq_strobe  = r_strobe;
    assign dreq_data    = r_data;
    assign mem_wb_state = r_wb;
    assign wb_valid     = r_wb_valid;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of execute. Consumes the ex_mem bundle and drives the data-bus request/response handshake for loads and stores.
- Aligns store data and byte strobes; extracts and sign/zero-extends load data.
- Registers the result into the mem_wb bundle for writeback.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- XLEN, 64, data/address width
- STRB_W, XLEN/8, byte-strobe width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_mem_state  in  ex_mem  from execute
  - alu_result (XLEN) is the address or ALU value.
  - store_data (XLEN) is rs2.
  - inst_signal carries mem_read, mem_write, mem_size[1:0] (0=B, 1=H, 2=W, 3=D) and mem_unsigned.
  - Also carries reg_dest_addr[4:0], reg_write_enable, inst[31:0], inst_pc[XLEN-1:0].
- ex_valid  in  1  ex_mem_state is valid this cycle
- mem_ready  out  1  stage can accept; upstream holds its state when 0
- dreq_valid  out  1  data request valid
- dreq_addr  out  XLEN  byte address
- dreq_size  out  3  log2 bytes
- dreq_strobe  out  STRB_W  write byte enables; all-zero means read
- dreq_data  out  XLEN  write data, lane-aligned
- dresp_data_ok  in  1  transaction complete; read data valid this cycle
- dresp_data  in  XLEN  read data, lane-aligned
- mem_wb_state  out  mem_wb  registered
  - reg_dest_addr, reg_write_enable, wb_value (XLEN), inst, inst_pc, inst_signal
- wb_valid  out  1  mem_wb_state valid

Behaviour:
- States: IDLE and BUSY.
- Reset (synchronous):
  - state goes to IDLE; wb_valid=0; mem_wb_state all-zero.
  - dreq_valid=0 and mem_ready=1 from the next cycle.
- mem_ready = (state==IDLE).
- dreq_* outputs are driven from a latched request register, not from ex_mem_state.
- IDLE, ex_valid=1, non-memory op:
  - At the next edge, mem_wb_state is loaded with wb_value=alu_result and wb_valid=1 (latency 1).
- IDLE, ex_valid=1, mem_read or mem_write:
  - Latch addr, size, strobe, aligned data and the instruction bundle.
  - Go to BUSY; wb_valid=0 at that edge.
- BUSY:
  - dreq_valid=1 and all dreq_* held stable until dresp_data_ok.
  - On dresp_data_ok, at the same edge: load mem_wb_state, set wb_valid=1, return to IDLE.
  - Loads: wb_value = extracted/extended data. Stores: wb_value=0, reg_write_enable=0.
- Latency:
  - memory op: N+1 cycles after acceptance, where N is the number of cycles until data_ok (min 1).
  - non-memory op: 1 cycle.
- wb_valid is a single-cycle pulse per instruction; it is 0 in any cycle with nothing completing.
- Store alignment, with offset o=addr[2:0]:
  - strobe = ((1<<(1<<size))-1) << o
  - dreq_data = store_data << (8*o)
- Load extraction: raw = dresp_data >> (8*o), truncated to the access size, then sign-extended, or zero-extended if mem_unsigned.
- Boundary conditions:
  - dresp_data_ok while IDLE is ignored.
  - ex_valid while BUSY is not accepted; upstream holds because mem_ready=0.
  - ex_valid=0 in IDLE: wb_valid=0 next cycle and mem_wb_state is unchanged.
  - Reset during BUSY: the request is dropped (dreq_valid=0 next cycle) and no writeback occurs. A late data_ok is ignored.
  - Address wrap is not handled; addresses pass through unchanged.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - An access with addr not aligned to its size issues no bus request and stays in IDLE.
  - mem_wb_state.inst_signal.misalign is set to 1, reg_write_enable=0, and wb_valid=1 next cycle.
- Undefined:
  - Low address bits below the size are forced to 0 (addr & ~((1<<size)-1)) before the request is issued.
  - The misalign field is absent.

Decomposition:
- Package temp_storage:
  - store_data field added to ex_mem.
  - mem_wb struct.
- Package common:
  - msize_t (2-bit size enum).
  - Strobe/width constants.
  - mem_state_t enum {IDLE, BUSY}.
- Sub-module mem_align (combinational):
  - Store path: store strobe/data generation.
  - Load path: load extract/extend.
  - Shared by both paths.

Test Plan:
- ADD result 0x1234, ex_valid=1 -> next cycle wb_valid=1, wb_value=0x1234, mem_ready stays 1, dreq_valid=0.
- SW addr 0x1004, data 0xDEADBEEF, data_ok after 3 cycles -> dreq_strobe=0xF0, dreq_data=0xDEADBEEF_00000000, dreq_size=2. mem_ready=0 for 3 cycles; wb_valid pulses with reg_write_enable=0.
- LB addr 0x2003, dresp_data=0x00000000_80000000 -> wb_value=0xFFFFFFFFFFFFFF80. The same access as LBU -> wb_value=0x80.
- LD addr 0x3000, data_ok in the first BUSY cycle -> wb_value=dresp_data, total latency 2 cycles; a back-to-back ex_valid is accepted the cycle after.
- Reset asserted during BUSY, then data_ok arrives -> dreq_valid=0 and wb_valid=0 after reset; the response is ignored and state is IDLE.
- LW addr 0x1002:
  - With MEM_MISALIGN_TRAP_EN: no dreq_valid; misalign=1 and wb_valid=1 next cycle.
  - Without it: dreq_addr=0x1000.
